// File: rtl/matrix_scan.sv
// HUB75 bit-plane scan engine: fetches each row pair plane by plane from a synchronous
// framebuffer, shifts it out column by column, latches it, then lights it for a plane-weighted time.
module matrix_scan #(
  parameter int COLUMNS      = 32,
  parameter int COLUMN_WIDTH = 5,
  parameter int ROW_PAIRS    = 16,
  parameter int ROW_WIDTH    = 4,
  parameter int PLANES       = 4,
  parameter int PLANE_WIDTH  = 2,
  parameter int BASE_ON_TIME = 32
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [2:0]              rgb_enable,
  output logic                    fb_rd_en,
  output logic [COLUMN_WIDTH-1:0] fb_column,
  output logic [ROW_WIDTH-1:0]    fb_row,
  output logic [PLANE_WIDTH-1:0]  fb_plane,
  input  logic [2:0]              fb_rgb_top,
  input  logic [2:0]              fb_rgb_bottom,
  output logic                    panel_clk,
  output logic [2:0]              panel_rgb1,
  output logic [2:0]              panel_rgb2,
  output logic [ROW_WIDTH-1:0]    panel_row,
  output logic                    panel_latch,
  output logic                    panel_oe_n,
  output logic                    frame_start
);

  // Holds BASE_ON_TIME << (PLANES-1) itself, so the longest plane never wraps the counter.
  localparam int ON_WIDTH = $clog2(BASE_ON_TIME << (PLANES - 1)) + 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD,
    S_CLOCK,
    S_BLANK,
    S_LATCH,
    S_SHOW
  } state_t;

  state_t                  state, next_state;
  logic                    running;
  logic [COLUMN_WIDTH-1:0] column, next_column;
  logic [ROW_WIDTH-1:0]    row, next_row;
  logic [PLANE_WIDTH-1:0]  plane, next_plane;
  logic [ON_WIDTH-1:0]     on_count, next_on_count;
  logic [ON_WIDTH-1:0]     on_load;

  logic last_column;
  logic last_row;
  logic last_plane;
  logic show_done;

  logic rd_d;
  logic clk_d;
  logic latch_d;
  logic oe_n_d;
  logic frame_start_d;

  assign last_column = (column == COLUMN_WIDTH'(COLUMNS - 1));
  assign last_row    = (row == ROW_WIDTH'(ROW_PAIRS - 1));
  assign last_plane  = (plane == PLANE_WIDTH'(PLANES - 1));
  assign show_done   = (on_count == '0);
  assign on_load     = (ON_WIDTH'(BASE_ON_TIME) << plane) - ON_WIDTH'(1);

  // State and scan counters. 'running' is clear only for the first cycle after reset
  // so that the first real FETCH presents its strobe and frame_start.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      running  <= 1'b0;
      column   <= '0;
      row      <= '0;
      plane    <= '0;
      on_count <= '0;
    end else begin
      state    <= next_state;
      running  <= 1'b1;
      column   <= next_column;
      row      <= next_row;
      plane    <= next_plane;
      on_count <= next_on_count;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state    = state;
    next_column   = column;
    next_row      = row;
    next_plane    = plane;
    next_on_count = on_count;
    if (!running) begin
      next_state = S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: next_state = S_LOAD;
        S_LOAD:  next_state = S_CLOCK;
        S_CLOCK: begin
          if (last_column) begin
            next_state = S_BLANK;
          end else begin
            next_state  = S_FETCH;
            next_column = column + 1'b1;
          end
        end
        S_BLANK: next_state = S_LATCH;
        S_LATCH: begin
          next_state    = S_SHOW;
          next_on_count = on_load;
        end
        S_SHOW: begin
          if (show_done) begin
            next_state  = S_FETCH;
            next_column = '0;
            if (last_plane) begin
              next_plane = '0;
              next_row   = last_row ? '0 : row + 1'b1;
            end else begin
              next_plane = plane + 1'b1;
            end
          end else begin
            next_on_count = on_count - 1'b1;
          end
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state and registered, so each one lines up
  // with the state it belongs to without any combinational path to the pins.
  always_comb begin
    rd_d          = (next_state == S_FETCH);
    clk_d         = (next_state == S_CLOCK);
    latch_d       = (next_state == S_LATCH);
    oe_n_d        = (next_state != S_SHOW);
    frame_start_d = (next_state == S_FETCH) && (next_column == '0) &&
                    (next_row == '0) && (next_plane == '0);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      fb_rd_en    <= 1'b0;
      fb_column   <= '0;
      fb_row      <= '0;
      fb_plane    <= '0;
      panel_clk   <= 1'b0;
      panel_rgb1  <= '0;
      panel_rgb2  <= '0;
      panel_row   <= '0;
      panel_latch <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      fb_rd_en    <= rd_d;
      fb_column   <= next_column;
      fb_row      <= next_row;
      fb_plane    <= next_plane;
      panel_clk   <= clk_d;
      panel_latch <= latch_d;
      panel_oe_n  <= oe_n_d;
      frame_start <= frame_start_d;
      // Framebuffer data arrives the cycle after the strobe; the mask is applied as it is captured.
      if (state == S_LOAD) begin
        panel_rgb1 <= fb_rgb_top & rgb_enable;
        panel_rgb2 <= fb_rgb_bottom & rgb_enable;
      end
      // Row address moves only while the panel is blanked.
      if (state == S_BLANK) begin
        panel_row <= row;
      end
    end
  end

endmodule

// File: doc/matrix_scan.md
Name: matrix_scan

Overview:
Downstream consumer of the UART control stage's rgb_enable output. Drives a HUB75-style LED panel (two half-panels shifted in parallel) from a synchronous framebuffer using bit-plane (binary code) modulation. Fetches pixel bit-planes, shifts them out column by column, latches them, and holds output-enable for a plane-weighted time. Per-channel masking is applied from rgb_enable.

Parameters:
COLUMNS, 32, pixels shifted per row
COLUMN_WIDTH, 5, width of column counter / fb_column
ROW_PAIRS, 16, scanned row pairs (top/bottom half drive simultaneously)
ROW_WIDTH, 4, width of row counters / panel_row / fb_row
PLANES, 4, bit planes per colour channel
PLANE_WIDTH, 2, width of fb_plane
BASE_ON_TIME, 32, clk_in cycles of OE for plane 0; plane p gets BASE_ON_TIME << p

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
rgb_enable  input  3  channel mask {B,G,R}; 0 forces that channel's data low
fb_rd_en  output  1  framebuffer read strobe
fb_column  output  COLUMN_WIDTH  column being fetched
fb_row  output  ROW_WIDTH  row pair being fetched
fb_plane  output  PLANE_WIDTH  bit plane being fetched
fb_rgb_top  input  3  plane bit {B,G,R} for top pixel, valid 1 cycle after fb_rd_en
fb_rgb_bottom  input  3  plane bit {B,G,R} for bottom pixel, same timing
panel_clk  output  1  shift clock to panel
panel_rgb1  output  3  top-half data
panel_rgb2  output  3  bottom-half data
panel_row  output  ROW_WIDTH  displayed row address
panel_latch  output  1  latch strobe
panel_oe_n  output  1  output enable, active low
frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (reset=0, async): state FETCH, column=0, row=0, plane=0; fb_rd_en=0, panel_clk=0, panel_rgb1/2=0, panel_row=0, panel_latch=0, panel_oe_n=1, frame_start=0, on-time counter=0. All outputs registered.
- FSM states: FETCH, LOAD, CLOCK, BLANK, LATCH, SHOW.
- FETCH (1 cycle): fb_rd_en=1, fb_column/fb_row/fb_plane = counters; panel_clk=0.
- LOAD (1 cycle): panel_clk=0; at end, panel_rgb1 <= fb_rgb_top & rgb_enable, panel_rgb2 <= fb_rgb_bottom & rgb_enable. rgb_enable sampled here only; a change affects subsequent pixels, never already-shifted ones.
- CLOCK (1 cycle): panel_clk=1, data stable. If column==COLUMNS-1 -> BLANK, else column+1 -> FETCH.
- Pixel period = 3 cycles; shift phase = 3*COLUMNS cycles.
- BLANK (1 cycle): panel_oe_n=1, panel_clk=0, panel_row <= fb_row.
- LATCH (1 cycle): panel_latch=1, oe_n=1. On-time counter loaded with (BASE_ON_TIME << plane) - 1.
- SHOW: panel_oe_n=0 for exactly BASE_ON_TIME << plane cycles, then column=0 -> FETCH; oe_n returns to 1 on the FETCH cycle.
- Counter advance on leaving SHOW: plane+1; at plane==PLANES-1 wrap plane to 0 and row+1; at row==ROW_PAIRS-1 also wrap row to 0.
- frame_start=1 during the FETCH cycle of column 0, row 0, plane 0. This includes the first FETCH after reset release.
- panel_oe_n is never 0 while panel_latch=1, panel_clk=1, or panel_row changes.
- Cycles per row-plane = 3*COLUMNS + 2 + (BASE_ON_TIME << plane). Defaults: plane0 130, plane3 354.
- Counter/shift widths: on-time counter wide enough for BASE_ON_TIME << (PLANES-1) (9 bits at defaults); no overflow at max.
- Reset mid-operation: immediate return to reset values, including oe_n=1 mid-SHOW and latch=0 mid-LATCH; restart at row 0 plane 0 with frame_start.

Test Plan:
- Release reset, framebuffer model returns top=3'b101, bottom=3'b010 with 1-cycle latency, rgb_enable=3'b111 -> frame_start pulses on first cycle; 32 panel_clk rising edges with panel_rgb1=101, panel_rgb2=010; latch pulse at cycle 97; oe_n low for 32 cycles.
- Count full row-plane sequence for row 0 -> OE-low widths 32, 64, 128, 256 for planes 0..3; fb_plane follows 0,1,2,3; fb_row increments to 1 after plane 3.
- Run to row 15 plane 3 -> row and plane wrap to 0; frame_start pulses again exactly once per frame; panel_row sequence 0..15.
- rgb_enable=3'b111 -> 3'b110 after pixel 10's LOAD -> pixels 0..10 carry R bit; pixels 11..31 have panel_rgb1[0]=panel_rgb2[0]=0.
- Assert reset for 1 cycle mid-SHOW of plane 2 -> oe_n=1 immediately; all outputs at reset values; restart with frame_start and fb_row=0, fb_plane=0.
- Protocol checker over 2 full frames -> oe_n never 0 with latch=1 or panel_clk=1; panel_row changes only while oe_n=1; fb_rd_en only in FETCH.
